split_tx: RTL and testbench

SPLIT_TX -- requirements
Module: split_tx

---
 rtl/split_tx_if.sv | 21 ++
 rtl/split_tx.sv | 129 ++++++++++++
 tb/tb_split_tx.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/split_tx_if.sv
// Word-in / byte-strobe-out bus of the split_tx serializer.
// The master drives the word side, and the slave (split_tx) drives the byte side.
interface split_tx_if;
    logic [15:0] word;
    logic        word_valid;
    logic        word_ready;
    logic [7:0]  sig;
    logic        flag;
    logic        busy;
    logic        done;

    modport master (
        output word, word_valid,
        input  word_ready, sig, flag, busy, done
    );

    modport slave (
        input  word, word_valid,
        output word_ready, sig, flag, busy, done
    );
endinterface

// File: rtl/split_tx.sv
// Splits an accepted 16-bit word into two bytes. Each byte gets a setup
// cycle, then a flag pulse FLAG_HIGH cycles long, then GAP cycles with the flag low.
module split_tx #(
    parameter int FLAG_HIGH = 1,
    parameter int GAP       = 2,
    parameter int MSB_FIRST = 1
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    split_tx_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE, SETUP0, HIGH0, LOW0, SETUP1, HIGH1, LOW1
    } state_t;

    localparam logic [7:0] HIGH_LOAD = 8'(FLAG_HIGH - 1);
    localparam logic [7:0] GAP_LOAD  = 8'(GAP - 1);

    state_t      state_reg, state_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic [15:0] word_reg, word_next;
    logic [7:0]  sig_reg, sig_next;
    logic        flag_reg, flag_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;
    logic        ready_reg, ready_next;
    logic        accept;
    logic [7:0]  first_byte;
    logic [7:0]  second_byte;

    // The first byte comes straight from the input word on the capture edge.
    // The second byte always comes from the captured copy.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign first_byte  = bus.word[15:8];
            assign second_byte = word_reg[7:0];
        end else begin : g_lsb_first
            assign first_byte  = bus.word[7:0];
            assign second_byte = word_reg[15:8];
        end
    endgenerate

    assign accept = (state_reg == IDLE) && ready_reg && bus.word_valid;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg - 8'd1;
        case (state_reg)
            IDLE: begin
                cnt_next = 8'd0;
                if (accept) state_next = SETUP0;
            end
            SETUP0: begin
                state_next = HIGH0;
                cnt_next   = HIGH_LOAD;
            end
            HIGH0: if (cnt_reg == 8'd0) begin
                state_next = LOW0;
                cnt_next   = GAP_LOAD;
            end
            LOW0: if (cnt_reg == 8'd0) begin
                state_next = SETUP1;
                cnt_next   = 8'd0;
            end
            SETUP1: begin
                state_next = HIGH1;
                cnt_next   = HIGH_LOAD;
            end
            HIGH1: if (cnt_reg == 8'd0) begin
                state_next = LOW1;
                cnt_next   = GAP_LOAD;
            end
            LOW1: if (cnt_reg == 8'd0) begin
                state_next = IDLE;
                cnt_next   = 8'd0;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 8'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state, so the registered values line up with the state.
    always_comb begin
        word_next  = word_reg;
        sig_next   = sig_reg;
        if (accept) begin
            word_next = bus.word;
            sig_next  = first_byte;
        end else if (state_reg == LOW0 && state_next == SETUP1) begin
            sig_next  = second_byte;
        end
        flag_next  = (state_next == HIGH0) || (state_next == HIGH1);
        busy_next  = (state_next != IDLE);
        ready_next = (state_next == IDLE);
        done_next  = (state_next == LOW1) && (cnt_next == 8'd0);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= 8'd0;
            word_reg  <= 16'h0000;
            sig_reg   <= 8'h00;
            flag_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            ready_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            word_reg  <= word_next;
            sig_reg   <= sig_next;
            flag_reg  <= flag_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            ready_reg <= ready_next;
        end
    end

    assign bus.word_ready = ready_reg;
    assign bus.sig        = sig_reg;
    assign bus.flag       = flag_reg;
    assign bus.busy       = busy_reg;
    assign bus.done       = done_reg;

endmodule

// File: tb/tb_split_tx.sv
// Directed bench for split_tx. It drives two instances: one with default
// parameters and one with FLAG_HIGH=3, GAP=1, LSB first.
module tb_split_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] w_a = 16'h0000, w_b = 16'h0000;
    logic        v_a = 1'b0, v_b = 1'b0;
    int          checks = 0;
    int          failures = 0;
    logic [7:0]  rx_q[$];

    split_tx_if ifa ();
    split_tx_if ifb ();

    assign ifa.word       = w_a;
    assign ifa.word_valid = v_a;
    assign ifb.word       = w_b;
    assign ifb.word_valid = v_b;

    split_tx u_a (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (ifa)
    );

    split_tx #(.FLAG_HIGH(3), .GAP(1), .MSB_FIRST(0)) u_b (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (ifb)
    );

    always #5 clk = ~clk;

    // Byte-pair receiver model: captures sig on every rising edge of flag.
    always @(posedge ifa.flag) rx_q.push_back(ifa.sig);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic accept(input bit s, input logic [15:0] w);
        int n = 0;
        @(negedge clk);
        while (((s ? ifb.word_ready : ifa.word_ready) !== 1'b1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("accept_wait_ready", s ? ifb.word_ready : ifa.word_ready, 1);
        if (s) begin w_b = w; v_b = 1'b1; end
        else   begin w_a = w; v_a = 1'b1; end
        $display("tx dut=%s word=%h", s ? "B" : "A", w);
        @(posedge clk);
        #1;
    endtask

    // Called just after the acceptance edge. It checks cycles 1..L+1 against the spec timing.
    task automatic track(input bit s, input logic [15:0] w, input int fh, input int gap,
                         input bit msb, input bit keep, input logic [15:0] nw);
        logic [7:0] b0, b1, e_sig;
        int p, l, j;
        bit e_flag;
        b0 = msb ? w[15:8] : w[7:0];
        b1 = msb ? w[7:0]  : w[15:8];
        p = 1 + fh + gap;
        l = 2 * p;
        if (s) begin w_b = keep ? 16'($urandom) : ~w; v_b = keep; end
        else   begin w_a = keep ? 16'($urandom) : ~w; v_a = keep; end
        for (int k = 1; k <= l + 1; k++) begin
            @(negedge clk);
            j = (k > p) ? k - p : k;
            e_flag = (k <= l) && (j >= 2) && (j <= 1 + fh);
            e_sig = (k > p) ? b1 : b0;
            check($sformatf("%s_c%0d_sig", s ? "B" : "A", k), s ? ifb.sig : ifa.sig, e_sig);
            check($sformatf("%s_c%0d_flag", s ? "B" : "A", k), s ? ifb.flag : ifa.flag, e_flag);
            check($sformatf("%s_c%0d_done", s ? "B" : "A", k), s ? ifb.done : ifa.done, k == l);
            check($sformatf("%s_c%0d_busy", s ? "B" : "A", k), s ? ifb.busy : ifa.busy, k <= l);
            check($sformatf("%s_c%0d_ready", s ? "B" : "A", k), s ? ifb.word_ready : ifa.word_ready, k > l);
            if (keep) begin
                if (s) w_b = (k == l + 1) ? nw : 16'($urandom);
                else   w_a = (k == l + 1) ? nw : 16'($urandom);
            end
        end
    endtask

    initial begin
        logic [15:0] rw;

        // Asynchronous reset: outputs must be at reset values before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("rst_sig", ifa.sig, 8'h00);
        check("rst_flag", ifa.flag, 0);
        check("rst_busy", ifa.busy, 0);
        check("rst_done", ifa.done, 0);
        check("rst_ready", ifa.word_ready, 0);
        repeat (3) @(negedge clk);
        check("rst_ready_held", ifa.word_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", ifa.word_ready, 1);
        check("post_rst_busy", ifa.busy, 0);

        // Idle for 20 cycles with no valid word.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("idle%0d_flag", i), ifa.flag, 0);
            check($sformatf("idle%0d_busy", i), ifa.busy, 0);
            check($sformatf("idle%0d_done", i), ifa.done, 0);
        end

        // Default timing with valid held high, followed by acceptance exactly in cycle 9.
        accept(0, 16'hA55A);
        track(0, 16'hA55A, 1, 2, 1, 1, 16'h0F3C);
        @(posedge clk);
        #1;
        track(0, 16'h0F3C, 1, 2, 1, 0, 16'h0000);

        // FLAG_HIGH=3, GAP=1, LSB first.
        accept(1, 16'h1234);
        track(1, 16'h1234, 3, 1, 0, 0, 16'h0000);

        // Loopback: 256 random words, two flag edges per word, with the bytes in order.
        for (int i = 0; i < 256; i++) begin
            rw = 16'($urandom);
            rx_q.delete();
            accept(0, rw);
            v_a = 1'b0;
            repeat (9) @(negedge clk);
            check($sformatf("lb%0d_edges", i), rx_q.size(), 2);
            if (rx_q.size() == 2) begin
                check($sformatf("lb%0d_b0", i), rx_q[0], rw[15:8]);
                check($sformatf("lb%0d_b1", i), rx_q[1], rw[7:0]);
            end
        end

        // Reset asserted during HIGH1 (cycle 6) aborts the word.
        accept(0, 16'hC33C);
        v_a = 1'b0;
        repeat (6) @(negedge clk);
        check("h1_flag", ifa.flag, 1);
        check("h1_sig", ifa.sig, 8'h3C);
        #2 rst_n = 1'b0;
        #1;
        check("arst_flag", ifa.flag, 0);
        check("arst_sig", ifa.sig, 8'h00);
        check("arst_busy", ifa.busy, 0);
        check("arst_ready", ifa.word_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rx_q.delete();
        @(negedge clk);
        check("rel_ready", ifa.word_ready, 1);
        check("rel_busy", ifa.busy, 0);
        repeat (15) @(negedge clk);
        check("rel_flag", ifa.flag, 0);
        check("rel_edges", rx_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
